// File: rtl/risc_regfile_sb.sv
// RiSC-16 register file: parametrised array with internal write-back source select,
// same-cycle write-to-read bypass and a pending-write scoreboard driving issue stalls.
module risc_regfile_sb #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned NUM_REGS = 8,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rB,
  input  logic [ADDR_W-1:0]   rA,
  input  logic [ADDR_W-1:0]   rC,
  input  logic                src2_sel,
  output logic [DATA_W-1:0]   reg_out1,
  output logic [DATA_W-1:0]   reg_out2,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [1:0]          wb_tgt,
  input  logic [DATA_W-1:0]   mem_out,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   wb_pc,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [1:0] TGT_MEM = 2'b00;
  localparam logic [1:0] TGT_ALU = 2'b01;
  localparam logic [1:0] TGT_PC1 = 2'b10;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_commit;
  logic                wb_clear;
  logic [ADDR_W-1:0]   src2_addr;
  logic                issue_set;

  // A register is not pending if it is R0 or is being written back this cycle.
  function automatic logic is_pending(input logic [ADDR_W-1:0]   a,
                                      input logic [NUM_REGS-1:0] bz,
                                      input logic                we,
                                      input logic [ADDR_W-1:0]   wa);
    return (a != '0) && bz[a] && !(we && (a == wa));
  endfunction

  always_comb begin
    wb_data = '0;
    unique case (wb_tgt)
      TGT_MEM: wb_data = mem_out;
      TGT_ALU: wb_data = alu_out;
      TGT_PC1: wb_data = wb_pc + DATA_W'(1);
      default: wb_data = '0;
    endcase
  end

  assign wb_commit = wb_we && (wb_addr != '0) && (wb_tgt != 2'b11);
  assign wb_clear  = wb_we && (wb_addr != '0);
  assign src2_addr = src2_sel ? rA : rC;

  // Bypassed combinational read ports.
  always_comb begin
    reg_out1 = '0;
    reg_out2 = '0;
    if (rB != '0) begin
      reg_out1 = (wb_commit && (rB == wb_addr)) ? wb_data : regs_q[rB];
    end
    if (src2_addr != '0) begin
      reg_out2 = (wb_commit && (src2_addr == wb_addr)) ? wb_data : regs_q[src2_addr];
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (issue_valid) begin
      hazard = is_pending(rB, busy_q, wb_we, wb_addr)
            || is_pending(src2_addr, busy_q, wb_we, wb_addr)
            || (issue_we && is_pending(issue_dest, busy_q, wb_we, wb_addr));
    end
  end

  assign issue_set = issue_valid && issue_we && (issue_dest != '0) && !hazard;

  // Clear before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_clear) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!rst_n) begin
        regs_q[i] <= '0;
      end else if (wb_commit && (wb_addr == ADDR_W'(i))) begin
        regs_q[i] <= wb_data;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_risc_regfile_sb.sv
// Directed table-driven bench for risc_regfile_sb: each record is one clock cycle,
// outputs checked just after inputs settle, before the next rising edge.
module tb_risc_regfile_sb;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NVEC     = 34;

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   rB, rA, rC;
  logic                src2_sel;
  logic [DATA_W-1:0]   reg_out1, reg_out2;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_addr;
  logic [1:0]          wb_tgt;
  logic [DATA_W-1:0]   mem_out, alu_out, wb_pc;
  logic                issue_valid, issue_we;
  logic [ADDR_W-1:0]   issue_dest;
  logic                hazard;
  logic [NUM_REGS-1:0] busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              rst_n;
    logic [2:0]        rb, ra, rc;
    logic              s2;
    logic              we;
    logic [2:0]        wa;
    logic [1:0]        tgt;
    logic [15:0]       mem, alu, pc;
    logic              iv, iwe;
    logic [2:0]        idst;
    logic [15:0]       e1, e2;
    logic              eh;
    logic [7:0]        eb;
  } vec_t;

  vec_t tv [NVEC];

  risc_regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .rB(rB), .rA(rA), .rC(rC), .src2_sel(src2_sel),
    .reg_out1(reg_out1), .reg_out2(reg_out2), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_tgt(wb_tgt), .mem_out(mem_out), .alu_out(alu_out), .wb_pc(wb_pc),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
    .hazard(hazard), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [2:0] rb_, logic [2:0] ra_, logic [2:0] rc_,
                              logic s2_, logic we_, logic [2:0] wa_, logic [1:0] tgt_,
                              logic [15:0] mem_, logic [15:0] alu_, logic [15:0] pc_,
                              logic iv_, logic iwe_, logic [2:0] idst_,
                              logic [15:0] e1_, logic [15:0] e2_, logic eh_, logic [7:0] eb_);
    vec_t v;
    v.rst_n = r;  v.rb = rb_; v.ra = ra_; v.rc = rc_; v.s2 = s2_;
    v.we = we_;   v.wa = wa_; v.tgt = tgt_;
    v.mem = mem_; v.alu = alu_; v.pc = pc_;
    v.iv = iv_;   v.iwe = iwe_; v.idst = idst_;
    v.e1 = e1_;   v.e2 = e2_; v.eh = eh_; v.eb = eb_;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; rB = v.rb; rA = v.ra; rC = v.rc; src2_sel = v.s2;
    wb_we = v.we; wb_addr = v.wa; wb_tgt = v.tgt;
    mem_out = v.mem; alu_out = v.alu; wb_pc = v.pc;
    issue_valid = v.iv; issue_we = v.iwe; issue_dest = v.idst;
  endtask

  initial begin
    //              rst rB rA rC s2 we wa tgt   mem      alu      pc      iv iwe id  out1     out2     hz busy
    tv[0]  = mk(1, 1, 0, 3, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
    tv[1]  = mk(1, 1, 0, 3, 0, 1, 1, 2'b01, 16'h1010, 16'hE380, 16'h3030, 0, 0, 0, 16'hE380, 16'h0000, 0, 8'h00);
    tv[2]  = mk(1, 1, 0, 6, 0, 1, 6, 2'b00, 16'hBEEF, 16'h2020, 16'h3030, 0, 0, 0, 16'hE380, 16'hBEEF, 0, 8'h00);
    tv[3]  = mk(1, 6, 7, 1, 1, 1, 7, 2'b10, 16'h1010, 16'h2020, 16'hF00D, 0, 0, 0, 16'hBEEF, 16'hF00E, 0, 8'h00);
    tv[4]  = mk(1, 2, 0, 7, 0, 1, 2, 2'b01, 16'h1010, 16'h1234, 16'h3030, 0, 0, 0, 16'h1234, 16'hF00E, 0, 8'h00);
    tv[5]  = mk(1, 2, 0, 1, 0, 1, 2, 2'b10, 16'h1010, 16'h2020, 16'hFFFF, 0, 0, 0, 16'h0000, 16'hE380, 0, 8'h00);
    tv[6]  = mk(1, 2, 0, 6, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0000, 16'hBEEF, 0, 8'h00);
    tv[7]  = mk(1, 0, 0, 0, 0, 1, 0, 2'b01, 16'h1010, 16'hC771, 16'h3030, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
    tv[8]  = mk(1, 5, 0, 0, 0, 1, 5, 2'b01, 16'h1010, 16'h5555, 16'h3030, 0, 0, 0, 16'h5555, 16'h0000, 0, 8'h00);
    tv[9]  = mk(1, 5, 0, 0, 0, 1, 5, 2'b11, 16'h9999, 16'h9999, 16'h9999, 0, 0, 0, 16'h5555, 16'h0000, 0, 8'h00);
    tv[10] = mk(1, 5, 0, 0, 1, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h5555, 16'h0000, 0, 8'h00);
    tv[11] = mk(1, 3, 3, 0, 1, 1, 3, 2'b01, 16'h1010, 16'hE3F1, 16'h3030, 0, 0, 0, 16'hE3F1, 16'hE3F1, 0, 8'h00);
    tv[12] = mk(1, 3, 0, 3, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'hE3F1, 16'hE3F1, 0, 8'h00);
    // scoreboard: set, RAW stall, wb release with bypass, set-wins-over-clear
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 1, 5, 16'h0000, 16'h0000, 0, 8'h00);
    tv[14] = mk(1, 5, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 0, 0, 16'h5555, 16'h0000, 1, 8'h20);
    tv[15] = mk(1, 5, 0, 0, 0, 1, 5, 2'b01, 16'h1010, 16'h0ABC, 16'h3030, 1, 0, 0, 16'h0ABC, 16'h0000, 0, 8'h20);
    tv[16] = mk(1, 5, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0ABC, 16'h0000, 0, 8'h00);
    tv[17] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 1, 5, 16'h0000, 16'h0000, 0, 8'h00);
    tv[18] = mk(1, 0, 0, 0, 0, 1, 5, 2'b01, 16'h1010, 16'h1111, 16'h3030, 1, 1, 5, 16'h0000, 16'h0000, 0, 8'h20);
    tv[19] = mk(1, 5, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h1111, 16'h0000, 0, 8'h20);
    // WAW, dest 0, issue_valid low, port-2 hazard, tgt=11 clears busy
    tv[20] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 1, 6, 16'h0000, 16'h0000, 0, 8'h20);
    tv[21] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 1, 6, 16'h0000, 16'h0000, 1, 8'h60);
    tv[22] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 1, 0, 16'h0000, 16'h0000, 0, 8'h60);
    tv[23] = mk(1, 5, 0, 0, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h1111, 16'h0000, 0, 8'h60);
    tv[24] = mk(1, 0, 6, 0, 1, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 0, 0, 16'h0000, 16'hBEEF, 1, 8'h60);
    tv[25] = mk(1, 6, 0, 0, 0, 1, 6, 2'b11, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'hBEEF, 16'h0000, 0, 8'h60);
    tv[26] = mk(1, 6, 0, 5, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'hBEEF, 16'h1111, 0, 8'h20);
    // build busy=0x08, then reset mid-run with a write and an issue presented
    tv[27] = mk(1, 0, 0, 0, 0, 1, 5, 2'b11, 16'h1010, 16'h2020, 16'h3030, 1, 1, 3, 16'h0000, 16'h0000, 0, 8'h20);
    tv[28] = mk(1, 1, 0, 7, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'hE380, 16'hF00E, 0, 8'h08);
    tv[29] = mk(0, 0, 0, 0, 0, 1, 4, 2'b01, 16'h1010, 16'h7777, 16'h3030, 1, 1, 2, 16'h0000, 16'h0000, 0, 8'h08);
    tv[30] = mk(1, 1, 0, 6, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
    tv[31] = mk(1, 7, 0, 4, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
    tv[32] = mk(1, 3, 0, 5, 0, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
    tv[33] = mk(1, 2, 6, 0, 1, 0, 0, 2'b00, 16'h1010, 16'h2020, 16'h3030, 1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);

    apply(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 8'h0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk("reg_out1", i, 32'(reg_out1), 32'(tv[i].e1));
      chk("reg_out2", i, 32'(reg_out2), 32'(tv[i].e2));
      chk("hazard",   i, 32'(hazard),   32'(tv[i].eh));
      chk("busy",     i, 32'(busy),     32'(tv[i].eb));
    end

    // Bypass value before the edge, stored value after it
    @(negedge clk);
    apply(mk(1, 3, 0, 0, 0, 1, 3, 2'b01, 16'h1010, 16'hE3F1, 16'h3030, 0, 0, 0, 16'h0, 16'h0, 0, 8'h0));
    #1;
    chk("bypass_pre", 0, 32'(reg_out1), 32'h0000_E3F1);
    @(posedge clk);
    #1;
    wb_we   = 1'b0;
    alu_out = 16'h0000;
    #1;
    chk("bypass_post", 0, 32'(reg_out1), 32'h0000_E3F1);
    chk("busy_final", 0, 32'(busy), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
